// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - 2-way set-associative instruction cache with AXI-style refill and uncached bypass
//
// Purpose:
//   Instruction cache that returns up to FETCH_W words in the same cycle as
//   the request on a hit. A cacheable miss fetches a whole line with an
//   INCR burst and writes it into the victim way. An uncached fetch issues a
//   single-beat read and does not touch the arrays. An invalidate-all request
//   clears every valid bit and LRU bit in one cycle.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   i_en, i_addr     fetch request and word-aligned byte address
//   cached           1 = cacheable fetch, 0 = uncached fetch
//   inv_en           invalidate-all request (honoured only in IDLE)
//   i_stall          request not served this cycle
//   i_ready          per-word valid flags for i_rdata
//   i_rdata          FETCH_W words, word k in bits [32k+31:32k]
//   ar*              read address channel (arsize/arburst constant)
//   rdata, rvalid,
//   rlast, rready    read data channel (rready constant 1)
module icache_assoc #(
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 64,
    parameter int FETCH_W    = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_en,
    input  logic [31:0]            i_addr,
    input  logic                   cached,
    input  logic                   inv_en,
    output logic                   i_stall,
    output logic [FETCH_W-1:0]     i_ready,
    output logic [32*FETCH_W-1:0]  i_rdata,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [31:0]            rdata,
    input  logic                   rvalid,
    input  logic                   rlast,
    output logic                   rready
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        INVAL,
        RF_REQ,
        RF_DATA,
        RF_DONE,
        UC_REQ,
        UC_DATA,
        UC_DONE
    } state_e;

    state_e                 state_q;
    logic                   arvalid_q;
    logic [3:0]             arid_q;
    logic [31:0]            araddr_q;
    logic [3:0]             arlen_q;
    logic [OFF_W-1:0]       cnt_q;
    logic [OFF_W-1:0]       cap_off_q;
    logic [IDX_W-1:0]       cap_idx_q;
    logic [TAG_W-1:0]       cap_tag_q;
    logic [31:0]            uc_data_q;
    logic [31:0]            rbuf_q [LINE_WORDS];

    logic [SETS-1:0]        valid_q [2];
    logic [SETS-1:0]        lru_q;
    logic [TAG_W-1:0]       tags_q [2][SETS];
    logic [31:0]            data_q [2][SETS*LINE_WORDS];

    logic [OFF_W-1:0]       a_off;
    logic [IDX_W-1:0]       a_idx;
    logic [TAG_W-1:0]       a_tag;
    logic                   hit0;
    logic                   hit1;
    logic                   hit;
    logic                   hit_way;
    logic                   victim;
    logic [OFF_W:0]         pos;

    assign a_off = i_addr[OFF_W+1:2];
    assign a_idx = i_addr[OFF_W+2 +: IDX_W];
    assign a_tag = i_addr[31 -: TAG_W];

    assign hit0    = valid_q[0][a_idx] && (tags_q[0][a_idx] == a_tag);
    assign hit1    = valid_q[1][a_idx] && (tags_q[1][a_idx] == a_tag);
    assign hit     = hit0 || hit1;
    // Way 0 wins if both ways ever match the same tag.
    assign hit_way = !hit0;

    // Prefer an empty way (way 0 first); otherwise evict the LRU way.
    assign victim = !valid_q[0][cap_idx_q] ? 1'b0 :
                    !valid_q[1][cap_idx_q] ? 1'b1 : lru_q[cap_idx_q];

    assign arvalid = arvalid_q;
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign rready  = 1'b1;

    // Fetch response. A word is returned only while offset+k stays inside the
    // line; the carry bit of pos marks words that would cross the line end.
    always_comb begin
        i_stall = 1'b1;
        i_ready = '0;
        i_rdata = '0;
        pos     = '0;
        case (state_q)
            IDLE: begin
                if (inv_en) begin
                    i_stall = 1'b1;
                end else if (i_en && cached && hit) begin
                    i_stall = 1'b0;
                    for (int k = 0; k < FETCH_W; k++) begin
                        pos = {1'b0, a_off} + (OFF_W+1)'(k);
                        if (!pos[OFF_W]) begin
                            i_ready[k]         = 1'b1;
                            i_rdata[32*k +: 32] = data_q[hit_way][{a_idx, pos[OFF_W-1:0]}];
                        end
                    end
                end else if (i_en) begin
                    i_stall = 1'b1;
                end else begin
                    i_stall = 1'b0;
                end
            end
            RF_DONE: begin
                i_stall = 1'b0;
                for (int k = 0; k < FETCH_W; k++) begin
                    pos = {1'b0, cap_off_q} + (OFF_W+1)'(k);
                    if (!pos[OFF_W]) begin
                        i_ready[k]         = 1'b1;
                        i_rdata[32*k +: 32] = rbuf_q[pos[OFF_W-1:0]];
                    end
                end
            end
            UC_DONE: begin
                i_stall      = 1'b0;
                i_ready[0]   = 1'b1;
                i_rdata[31:0] = uc_data_q;
            end
            default: i_stall = 1'b1;
        endcase
        if (!resetn) begin
            i_stall = 1'b0;
            i_ready = '0;
            i_rdata = '0;
        end
    end

    // Control FSM, address channel registers and valid/LRU state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            cnt_q     <= '0;
            cap_off_q <= '0;
            cap_idx_q <= '0;
            cap_tag_q <= '0;
            uc_data_q <= '0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inv_en) begin
                        state_q <= INVAL;
                    end else if (i_en && cached && hit) begin
                        lru_q[a_idx] <= ~hit_way;
                    end else if (i_en && cached) begin
                        araddr_q  <= {i_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                        arlen_q   <= 4'(LINE_WORDS - 1);
                        arid_q    <= 4'h3;
                        arvalid_q <= 1'b1;
                        cnt_q     <= '0;
                        cap_off_q <= a_off;
                        cap_idx_q <= a_idx;
                        cap_tag_q <= a_tag;
                        state_q   <= RF_REQ;
                    end else if (i_en) begin
                        araddr_q  <= i_addr;
                        arlen_q   <= 4'h0;
                        arid_q    <= 4'h2;
                        arvalid_q <= 1'b1;
                        state_q   <= UC_REQ;
                    end
                end
                INVAL: begin
                    valid_q[0] <= '0;
                    valid_q[1] <= '0;
                    lru_q      <= '0;
                    state_q    <= IDLE;
                end
                RF_REQ: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= RF_DATA;
                    end
                end
                RF_DATA: begin
                    if (rvalid) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (rlast) begin
                            valid_q[victim][cap_idx_q] <= 1'b1;
                            lru_q[cap_idx_q]           <= ~victim;
                            state_q                    <= RF_DONE;
                        end
                    end
                end
                RF_DONE: state_q <= IDLE;
                UC_REQ: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= UC_DATA;
                    end
                end
                UC_DATA: begin
                    if (rvalid && rlast) begin
                        uc_data_q <= rdata;
                        state_q   <= UC_DONE;
                    end
                end
                UC_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Refill buffer and tag/data arrays. The last beat goes straight into the
    // array alongside the buffered beats so the line lands in one write.
    always_ff @(posedge clk) begin
        if (resetn && (state_q == RF_DATA) && rvalid) begin
            rbuf_q[cnt_q] <= rdata;
            if (rlast) begin
                tags_q[victim][cap_idx_q] <= cap_tag_q;
                for (int w = 0; w < LINE_WORDS; w++) begin
                    data_q[victim][{cap_idx_q, OFF_W'(w)}] <=
                        (OFF_W'(w) == cnt_q) ? rdata : rbuf_q[w];
                end
            end
        end
    end

endmodule
